// File: rtl/dpc_pkg.sv
// ---------------------------------------------------------------------------
// dpc_pkg
// Shared types and constants for the defective-pixel corrector.
//   dir_t      : interpolation direction picked for a pixel
//   NB_W11..33 : bit positions of each neighbour inside the nb_vld vector
//   NUM_PAIRS  : number of opposing neighbour pairs (H, V, D, A)
// ---------------------------------------------------------------------------
package dpc_pkg;

    typedef enum logic [2:0] {
        DIR_H      = 3'd0,
        DIR_V      = 3'd1,
        DIR_D      = 3'd2,
        DIR_A      = 3'd3,
        DIR_SINGLE = 3'd4,
        DIR_NONE   = 3'd5
    } dir_t;

    localparam int NB_W11 = 0;
    localparam int NB_W12 = 1;
    localparam int NB_W13 = 2;
    localparam int NB_W21 = 3;
    localparam int NB_W23 = 4;
    localparam int NB_W31 = 5;
    localparam int NB_W32 = 6;
    localparam int NB_W33 = 7;

    localparam int NUM_PAIRS = 4;

endpackage

// File: rtl/dpc_dir_select.sv
// ---------------------------------------------------------------------------
// dpc_dir_select
// Two pipeline stages of the corrector datapath.
//   Stage 1: per pair (H, V, D, A) computes usability, |a-b| and (a+b)>>1,
//            plus the first usable single neighbour as a fallback.
//   Stage 2: picks the usable pair with the smallest difference
//            (ties H>V>D>A), else the single neighbour, else nothing.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   advance           pipeline shift enable (hold when low)
//   in_*              pixel, flags and 3x3 neighbourhood entering stage 1
//   out_*             stage-2 outputs: sideband, centre, candidate, cand_ok
// ---------------------------------------------------------------------------
module dpc_dir_select
    import dpc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_centre,
    input  logic             in_bp,
    input  logic             in_enable,
    input  logic             in_tuser,
    input  logic             in_tlast,
    input  logic [WIDTH-1:0] w11,
    input  logic [WIDTH-1:0] w12,
    input  logic [WIDTH-1:0] w13,
    input  logic [WIDTH-1:0] w21,
    input  logic [WIDTH-1:0] w23,
    input  logic [WIDTH-1:0] w31,
    input  logic [WIDTH-1:0] w32,
    input  logic [WIDTH-1:0] w33,
    input  logic [7:0]       nb_vld,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_centre,
    output logic             out_bp,
    output logic             out_enable,
    output logic             out_tuser,
    output logic             out_tlast,
    output logic [WIDTH-1:0] out_cand,
    output logic             out_cand_ok
);

    // index 0 = H, 1 = V, 2 = D, 3 = A
    logic [NUM_PAIRS-1:0][WIDTH-1:0] pair_a_s, pair_b_s, diff_s, avg_s;
    logic [NUM_PAIRS-1:0][WIDTH:0]   sum_s;
    logic [NUM_PAIRS-1:0]            pair_ok_s;
    logic [WIDTH-1:0]                single_s;
    logic                            single_ok_s;

    logic                            s1_valid_r, s1_bp_r, s1_enable_r, s1_tuser_r, s1_tlast_r;
    logic [WIDTH-1:0]                s1_centre_r;
    logic [NUM_PAIRS-1:0][WIDTH-1:0] s1_diff_r, s1_avg_r;
    logic [NUM_PAIRS-1:0]            s1_ok_r;
    logic [WIDTH-1:0]                s1_single_r;
    logic                            s1_single_ok_r;

    dir_t                            dir_s;
    logic [WIDTH-1:0]                best_diff_s, cand_s;
    logic                            found_s;

    // Stage 1 combinational: pair metrics and the single-neighbour fallback
    always_comb begin
        pair_a_s  = {w13, w11, w12, w21};
        pair_b_s  = {w31, w33, w32, w23};
        pair_ok_s = {nb_vld[NB_W13] & nb_vld[NB_W31],
                     nb_vld[NB_W11] & nb_vld[NB_W33],
                     nb_vld[NB_W12] & nb_vld[NB_W32],
                     nb_vld[NB_W21] & nb_vld[NB_W23]};
        sum_s  = '0;
        diff_s = '0;
        avg_s  = '0;
        for (int i = 0; i < NUM_PAIRS; i++) begin
            diff_s[i] = (pair_a_s[i] >= pair_b_s[i]) ? (pair_a_s[i] - pair_b_s[i])
                                                     : (pair_b_s[i] - pair_a_s[i]);
            // one extra bit so the sum of two full-scale pixels cannot wrap
            sum_s[i]  = {1'b0, pair_a_s[i]} + {1'b0, pair_b_s[i]};
            avg_s[i]  = sum_s[i][WIDTH:1];
        end
        single_ok_s = 1'b1;
        if      (nb_vld[NB_W21]) single_s = w21;
        else if (nb_vld[NB_W23]) single_s = w23;
        else if (nb_vld[NB_W12]) single_s = w12;
        else if (nb_vld[NB_W32]) single_s = w32;
        else if (nb_vld[NB_W11]) single_s = w11;
        else if (nb_vld[NB_W13]) single_s = w13;
        else if (nb_vld[NB_W31]) single_s = w31;
        else if (nb_vld[NB_W33]) single_s = w33;
        else begin
            single_s    = '0;
            single_ok_s = 1'b0;
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r     <= 1'b0;
            s1_centre_r    <= '0;
            s1_bp_r        <= 1'b0;
            s1_enable_r    <= 1'b0;
            s1_tuser_r     <= 1'b0;
            s1_tlast_r     <= 1'b0;
            s1_diff_r      <= '0;
            s1_avg_r       <= '0;
            s1_ok_r        <= '0;
            s1_single_r    <= '0;
            s1_single_ok_r <= 1'b0;
        end else if (advance) begin
            s1_valid_r     <= in_valid;
            s1_centre_r    <= in_centre;
            s1_bp_r        <= in_bp;
            s1_enable_r    <= in_enable;
            s1_tuser_r     <= in_tuser;
            s1_tlast_r     <= in_tlast;
            s1_diff_r      <= diff_s;
            s1_avg_r       <= avg_s;
            s1_ok_r        <= pair_ok_s;
            s1_single_r    <= single_s;
            s1_single_ok_r <= single_ok_s;
        end
    end

    // Stage 2 combinational: minimum-difference pair; strict '<' keeps H>V>D>A on ties
    always_comb begin
        found_s     = 1'b0;
        best_diff_s = '0;
        dir_s       = DIR_NONE;
        for (int i = 0; i < NUM_PAIRS; i++) begin
            if (s1_ok_r[i] && (!found_s || (s1_diff_r[i] < best_diff_s))) begin
                found_s     = 1'b1;
                best_diff_s = s1_diff_r[i];
                dir_s       = dir_t'(i[2:0]);
            end else begin
                found_s     = found_s;
            end
        end
        if (!found_s && s1_single_ok_r) begin
            dir_s = DIR_SINGLE;
        end else begin
            dir_s = dir_s;
        end
        case (dir_s)
            DIR_H:      cand_s = s1_avg_r[0];
            DIR_V:      cand_s = s1_avg_r[1];
            DIR_D:      cand_s = s1_avg_r[2];
            DIR_A:      cand_s = s1_avg_r[3];
            DIR_SINGLE: cand_s = s1_single_r;
            default:    cand_s = s1_centre_r;
        endcase
    end

    // Stage 2 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_centre  <= '0;
            out_bp      <= 1'b0;
            out_enable  <= 1'b0;
            out_tuser   <= 1'b0;
            out_tlast   <= 1'b0;
            out_cand    <= '0;
            out_cand_ok <= 1'b0;
        end else if (advance) begin
            out_valid   <= s1_valid_r;
            out_centre  <= s1_centre_r;
            out_bp      <= s1_bp_r;
            out_enable  <= s1_enable_r;
            out_tuser   <= s1_tuser_r;
            out_tlast   <= s1_tlast_r;
            out_cand    <= cand_s;
            out_cand_ok <= (dir_s != DIR_NONE);
        end
    end

endmodule

// File: rtl/dpc_corrector.sv
// ---------------------------------------------------------------------------
// dpc_corrector
// Replaces pixels flagged bad by the detector with a gradient-directed
// interpolation of usable neighbours; 3-stage pipeline, AXI-Stream in/out,
// per-frame count of corrected pixels.
// Ports:
//   aclk, areset              clock, asynchronous active-high reset
//   enable                    1 = correct, 0 = bypass (travels with the pixel)
//   s_axis_*                  input pixel stream, s_axis_bp = centre is bad
//   w11..w33, nb_vld          3x3 neighbourhood and per-neighbour usable flags
//   m_axis_*                  output stream, m_axis_corr = pixel replaced
//   frame_done                one-cycle pulse after the last pixel of a frame
//   corrected_count           corrections in the last completed frame
// ---------------------------------------------------------------------------
module dpc_corrector
    import dpc_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CNT_WIDTH    = 10,
    parameter int FRAME_HEIGHT = 10,
    parameter int STAT_WIDTH   = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  enable,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [WIDTH-1:0]      s_axis_tdata,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_bp,
    input  logic [WIDTH-1:0]      w11,
    input  logic [WIDTH-1:0]      w12,
    input  logic [WIDTH-1:0]      w13,
    input  logic [WIDTH-1:0]      w21,
    input  logic [WIDTH-1:0]      w23,
    input  logic [WIDTH-1:0]      w31,
    input  logic [WIDTH-1:0]      w32,
    input  logic [WIDTH-1:0]      w33,
    input  logic [7:0]            nb_vld,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [WIDTH-1:0]      m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  m_axis_corr,
    output logic                  frame_done,
    output logic [STAT_WIDTH-1:0] corrected_count
);

    logic                  advance_s, accept_s, replace_s, out_hs_s, frame_end_s;
    logic                  ready_en_r;
    logic                  s2_valid_s, s2_bp_s, s2_enable_s, s2_tuser_s, s2_tlast_s, s2_cand_ok_s;
    logic [WIDTH-1:0]      s2_centre_s, s2_cand_s;
    logic [CNT_WIDTH-1:0]  row_r, row_base_s;
    logic [STAT_WIDTH-1:0] run_r, run_base_s, run_next_s;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + STAT_WIDTH'(1);
        end
    endfunction

    // Handshake: the whole pipeline moves whenever the output register can drain
    always_comb begin
        advance_s     = !m_axis_tvalid || m_axis_tready;
        s_axis_tready = advance_s && ready_en_r;
        accept_s      = s_axis_tvalid && s_axis_tready;
    end

    // Holds input ready low until the first clock after reset release
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    dpc_dir_select #(.WIDTH(WIDTH)) u_dir_select (
        .clk         (aclk),
        .rst         (areset),
        .advance     (advance_s),
        .in_valid    (accept_s),
        .in_centre   (s_axis_tdata),
        .in_bp       (s_axis_bp),
        .in_enable   (enable),
        .in_tuser    (s_axis_tuser),
        .in_tlast    (s_axis_tlast),
        .w11         (w11),
        .w12         (w12),
        .w13         (w13),
        .w21         (w21),
        .w23         (w23),
        .w31         (w31),
        .w32         (w32),
        .w33         (w33),
        .nb_vld      (nb_vld),
        .out_valid   (s2_valid_s),
        .out_centre  (s2_centre_s),
        .out_bp      (s2_bp_s),
        .out_enable  (s2_enable_s),
        .out_tuser   (s2_tuser_s),
        .out_tlast   (s2_tlast_s),
        .out_cand    (s2_cand_s),
        .out_cand_ok (s2_cand_ok_s)
    );

    // Stage 3 combinational: replace only bad pixels in correct mode with a candidate
    always_comb begin
        replace_s = s2_enable_s && s2_bp_s && s2_cand_ok_s;
    end

    // Stage 3 / output register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_corr   <= 1'b0;
        end else if (advance_s) begin
            m_axis_tvalid <= s2_valid_s;
            m_axis_tdata  <= replace_s ? s2_cand_s : s2_centre_s;
            m_axis_tuser  <= s2_tuser_s;
            m_axis_tlast  <= s2_tlast_s;
            m_axis_corr   <= s2_valid_s && replace_s;
        end
    end

    // Frame bookkeeping: an output SOF restarts row and running count, so a
    // correction on the SOF pixel itself belongs to the new frame
    always_comb begin
        out_hs_s    = m_axis_tvalid && m_axis_tready;
        row_base_s  = m_axis_tuser ? '0 : row_r;
        run_base_s  = m_axis_tuser ? '0 : run_r;
        run_next_s  = m_axis_corr ? sat_inc(run_base_s) : run_base_s;
        frame_end_s = out_hs_s && m_axis_tlast &&
                      (row_base_s == CNT_WIDTH'(FRAME_HEIGHT - 1));
    end

    // Row counter, running count, per-frame statistic and frame_done pulse
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            row_r           <= '0;
            run_r           <= '0;
            corrected_count <= '0;
            frame_done      <= 1'b0;
        end else begin
            frame_done <= frame_end_s;
            if (frame_end_s) begin
                corrected_count <= run_next_s;
                run_r           <= '0;
                row_r           <= '0;
            end else if (out_hs_s) begin
                run_r <= run_next_s;
                row_r <= m_axis_tlast ? (row_base_s + CNT_WIDTH'(1)) : row_base_s;
            end
        end
    end

endmodule

// File: tb/tb_dpc_corrector.sv
// ---------------------------------------------------------------------------
// tb_dpc_corrector
// Directed bench: a table of single-pixel vectors with hand-computed results,
// then full 10x10 frames with random output back-pressure, a mid-frame reset
// and a follow-up frame.
// ---------------------------------------------------------------------------
module tb_dpc_corrector;

    localparam int W = 16;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          enable = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [W-1:0]  s_axis_tdata = '0;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_bp = 1'b0;
    logic [W-1:0]  w11 = '0, w12 = '0, w13 = '0, w21 = '0, w23 = '0, w31 = '0, w32 = '0, w33 = '0;
    logic [7:0]    nb_vld = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          m_axis_corr;
    logic          frame_done;
    logic [15:0]   corrected_count;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 aclk = ~aclk;

    dpc_corrector dut (
        .aclk            (aclk),
        .areset          (areset),
        .enable          (enable),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_bp       (s_axis_bp),
        .w11             (w11),
        .w12             (w12),
        .w13             (w13),
        .w21             (w21),
        .w23             (w23),
        .w31             (w31),
        .w32             (w32),
        .w33             (w33),
        .nb_vld          (nb_vld),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_corr     (m_axis_corr),
        .frame_done      (frame_done),
        .corrected_count (corrected_count)
    );

    // neighbour order matches nb_vld bits: [0]w11 [1]w12 [2]w13 [3]w21 [4]w23 [5]w31 [6]w32 [7]w33
    typedef struct {
        logic [W-1:0]        centre;
        logic                bp;
        logic                en;
        logic [7:0][W-1:0]   w;
        logic [7:0]          nb;
        logic [W-1:0]        exp_data;
        logic                exp_corr;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] c, input logic bp, input logic en,
                         input logic [7:0][W-1:0] w, input logic [7:0] nb,
                         input logic su, input logic sl);
        s_axis_tdata = c;  s_axis_bp = bp;  enable = en;
        w11 = w[0]; w12 = w[1]; w13 = w[2]; w21 = w[3];
        w23 = w[4]; w31 = w[5]; w32 = w[6]; w33 = w[7];
        nb_vld = nb;  s_axis_tuser = su;  s_axis_tlast = sl;
    endtask

    function automatic logic is_bad(input int p);
        return (p == 23) || (p == 64) || (p == 87);   // (2,3) (6,4) (8,7)
    endfunction

    // expected {data, tuser, tlast, corr} of frame pixel p
    function automatic logic [31:0] exp_pix(input int p);
        logic [W-1:0] d;
        d = is_bad(p) ? 16'd2000 : 16'(100 + p);
        return {13'd0, d, (p == 0), ((p % 10) == 9), is_bad(p)};
    endfunction

    // Streams one 10x10 frame with random output ready; stops after stop_out outputs
    task automatic run_frame(input int stop_out, input string tag);
        logic [7:0][W-1:0] fw;
        int idx_in, idx_out, cyc;
        fw = {16'd4000, 16'd4000, 16'd4000, 16'd2000, 16'd2000, 16'd0, 16'd0, 16'd0};
        idx_in = 0; idx_out = 0; cyc = 0;
        while (idx_out < stop_out && cyc < 3000) begin
            @(negedge aclk);
            m_axis_tready = 1'($urandom_range(0, 1));
            if (idx_in < 100) begin
                drive(16'(100 + idx_in), is_bad(idx_in), 1'b1, fw, 8'hFF,
                      idx_in == 0, (idx_in % 10) == 9);
                s_axis_tvalid = 1'b1;
            end else begin
                s_axis_tvalid = 1'b0;
            end
            #1;
            if (frame_done) done_cnt++;
            if (m_axis_tvalid && m_axis_tready) begin
                check($sformatf("%s_pix%0d", tag, idx_out),
                      {13'd0, m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_corr},
                      exp_pix(idx_out));
                idx_out++;
            end
            if (s_axis_tvalid && s_axis_tready) idx_in++;
            cyc++;
        end
        if (idx_out < stop_out) check({tag, "_timeout"}, 32'(idx_out), 32'(stop_out));
    endtask

    task automatic finish_frame(input string tag);
        s_axis_tvalid = 1'b0;
        repeat (4) begin
            @(negedge aclk);
            #1;
            if (frame_done) done_cnt++;
        end
        check({tag, "_count"}, 32'(corrected_count), 32'd3);
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        logic [7:0][W-1:0] base_w, tie_w, sat_w, abs_w, trunc_w, d_w;
        base_w = {16'd1400, 16'd1300, 16'd1500, 16'd1020, 16'd1000, 16'd700, 16'd900, 16'd800};
        tie_w  = base_w; tie_w[3] = 16'd1000; tie_w[4] = 16'd1010; tie_w[1] = 16'd2000; tie_w[6] = 16'd2010;
        sat_w  = base_w; sat_w[3] = 16'hFFFF; sat_w[4] = 16'hFFFF;
        abs_w  = base_w; abs_w[3] = 16'd3000; abs_w[4] = 16'd100;
        trunc_w = base_w; trunc_w[2] = 16'd701;
        d_w    = base_w; d_w[0] = 16'd850;

        vecs[0]  = '{16'd500, 1'b1, 1'b1, base_w,  8'hFF, 16'd1010, 1'b1};  // H smallest
        vecs[1]  = '{16'd500, 1'b1, 1'b1, base_w,  8'hF7, 16'd1100, 1'b1};  // w21 unusable -> V
        vecs[2]  = '{16'd500, 1'b1, 1'b1, base_w,  8'h00, 16'd500,  1'b0};  // nothing usable
        vecs[3]  = '{16'd500, 1'b1, 1'b1, tie_w,   8'h5A, 16'd1005, 1'b1};  // H/V tie -> H
        vecs[4]  = '{16'd500, 1'b0, 1'b1, tie_w,   8'h5A, 16'd500,  1'b0};  // not bad
        vecs[5]  = '{16'd500, 1'b1, 1'b0, tie_w,   8'h5A, 16'd500,  1'b0};  // bypass
        vecs[6]  = '{16'd500, 1'b1, 1'b1, sat_w,   8'hFF, 16'hFFFF, 1'b1};  // full-scale average
        vecs[7]  = '{16'd500, 1'b1, 1'b1, base_w,  8'h80, 16'd1400, 1'b1};  // single w33
        vecs[8]  = '{16'd500, 1'b1, 1'b1, base_w,  8'h21, 16'd800,  1'b1};  // w11 before w31
        vecs[9]  = '{16'd500, 1'b1, 1'b1, d_w,     8'hA5, 16'd1125, 1'b1};  // D beats A
        vecs[10] = '{16'd500, 1'b1, 1'b1, trunc_w, 8'h24, 16'd1100, 1'b1};  // A, 2201>>1
        vecs[11] = '{16'd500, 1'b1, 1'b1, abs_w,   8'hFF, 16'd1100, 1'b1};  // |100-3000| large
        vecs[12] = '{16'd500, 1'b1, 1'b1, base_w,  8'h50, 16'd1020, 1'b1};  // single w23 before w32

        // reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_count",  32'(corrected_count), 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        check("ready_after_rst", 32'(s_axis_tready), 32'd1);

        // table-driven single pixels; output must appear exactly three clocks after acceptance
        m_axis_tready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            @(negedge aclk);
            drive(vecs[i].centre, vecs[i].bp, vecs[i].en, vecs[i].w, vecs[i].nb, 1'b0, 1'b0);
            s_axis_tvalid = 1'b1;
            @(posedge aclk);
            #1;
            s_axis_tvalid = 1'b0;
            @(posedge aclk);
            #1;
            check($sformatf("v%0d_early", i), 32'(m_axis_tvalid), 32'd0);
            @(posedge aclk);
            #1;
            check($sformatf("v%0d_valid", i), 32'(m_axis_tvalid), 32'd1);
            check($sformatf("v%0d_data", i),  32'(m_axis_tdata), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_corr", i),  32'(m_axis_corr),  32'(vecs[i].exp_corr));
        end

        // clean start for frame statistics
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;

        // full frame under random back-pressure
        done_cnt = 0;
        run_frame(100, "f1");
        finish_frame("f1");

        // reset in the middle of row 5
        run_frame(55, "f2");
        @(negedge aclk);
        areset = 1'b1;
        #1;
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_tdata",  32'(m_axis_tdata),  32'd0);
        check("mid_rst_tready", 32'(s_axis_tready), 32'd0);
        check("mid_rst_count",  32'(corrected_count), 32'd0);
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        areset = 1'b0;

        // the next complete frame is counted from scratch
        done_cnt = 0;
        run_frame(100, "f3");
        finish_frame("f3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
